// File: rtl/rtc_alarm_core.sv
// rtc_alarm_core: hh:mm:ss timekeeper driven by a 1 s enable, N_ALARM alarm channels,
// key-driven edit FSM and ring reporting. Define SNOOZE_EN to build in per-channel snooze.

module rtc_alarm_chan (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       h_inc,
  input  logic       h_dec,
  input  logic       m_inc,
  input  logic       m_dec,
  input  logic       adv,
  input  logic [4:0] nx_hour,
  input  logic [5:0] nx_min,
  input  logic       nx_top,
  input  logic       en,
  input  logic       excl,
`ifdef SNOOZE_EN
  input  logic       sn_load,
  input  logic       sn_cancel,
  input  logic [4:0] sn_hour,
  input  logic [5:0] sn_min,
`endif
  output logic [4:0] al_hour,
  output logic [5:0] al_min,
  output logic       hit
);

  logic al_hit;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      al_hour <= 5'd0;
      al_min  <= 6'd5;
    end else begin
      if (h_inc)      al_hour <= (al_hour == 5'd23) ? 5'd0 : al_hour + 5'd1;
      else if (h_dec) al_hour <= (al_hour == 5'd0) ? 5'd23 : al_hour - 5'd1;
      if (m_inc)      al_min  <= (al_min == 6'd59) ? 6'd0 : al_min + 6'd1;
      else if (m_dec) al_min  <= (al_min == 6'd0) ? 6'd59 : al_min - 6'd1;
    end
  end

  // The channel under edit is masked so half-entered values never fire.
  assign al_hit = en && !excl && (nx_hour == al_hour) && (nx_min == al_min);

`ifdef SNOOZE_EN
  logic       sn_vld;
  logic [4:0] sn_h;
  logic [5:0] sn_m;
  logic       sn_hit;

  assign sn_hit = sn_vld && (nx_hour == sn_h) && (nx_min == sn_m);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sn_vld <= 1'b0;
      sn_h   <= 5'd0;
      sn_m   <= 6'd0;
    end else if (sn_load) begin
      sn_vld <= 1'b1;
      sn_h   <= sn_hour;
      sn_m   <= sn_min;
    end else if (sn_cancel) begin
      sn_vld <= 1'b0;
    end else if (adv && nx_top && sn_hit) begin
      sn_vld <= 1'b0;
    end
  end

  assign hit = adv && nx_top && (al_hit || sn_hit);
`else
  assign hit = adv && nx_top && al_hit;
`endif

endmodule

module rtc_alarm_core #(
  parameter int N_ALARM    = 2,
  parameter int RING_SEC   = 10,
  parameter int SNOOZE_MIN = 5,
  parameter int TW         = 3
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               tick_1s,
  input  logic               key_mode,
  input  logic               key_inc,
  input  logic               key_dec,
  input  logic [TW-1:0]      set_tgt,
  input  logic [N_ALARM-1:0] alarm_en,
  output logic [4:0]         hour,
  output logic [5:0]         min,
  output logic [5:0]         sec,
  output logic [1:0]         edit_field,
  output logic [TW-1:0]      edit_tgt,
  input  logic [TW-1:0]      rd_idx,
  output logic [4:0]         rd_hour,
  output logic [5:0]         rd_min,
  output logic               ring,
  output logic [N_ALARM-1:0] ring_ch
);

  if (N_ALARM < 1 || N_ALARM > 7) begin : g_bad_n
    $error("N_ALARM must be 1..7");
  end
  if ((1 << TW) <= N_ALARM) begin : g_bad_tw
    $error("TW too narrow for N_ALARM");
  end
  if (RING_SEC < 1 || RING_SEC > 255) begin : g_bad_ring
    $error("RING_SEC must be 1..255");
  end
  if (SNOOZE_MIN < 1 || SNOOZE_MIN > 59) begin : g_bad_snz
    $error("SNOOZE_MIN must be 1..59");
  end

  typedef enum logic [1:0] {RUN = 2'd0, SET_H = 2'd1, SET_M = 2'd2, SET_S = 2'd3} state_t;

  state_t                   state, state_nx;
  logic                     editing, time_edit, adv;
  logic                     ed_inc, ed_dec, ack, ack_dec, ack_inc;
  logic [4:0]               hour_nx;
  logic [5:0]               min_nx, sec_nx;
  logic [7:0]               ring_cnt;
  logic [N_ALARM-1:0]       hit;
  logic [N_ALARM-1:0][4:0]  al_hour;
  logic [N_ALARM-1:0][5:0]  al_min;

  function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] top,
                                           input logic up);
    if (up) return (v == top) ? 6'd0 : v + 6'd1;
    return (v == 6'd0) ? top : v - 6'd1;
  endfunction

  assign editing   = (state != RUN);
  assign time_edit = editing && (edit_tgt == '0);
  assign adv       = tick_1s && !time_edit;

  // key_mode > key_inc > key_dec; while ringing, inc/dec are consumed as acknowledge.
  assign ack     = ring && !key_mode && (key_inc || key_dec);
  assign ack_inc = ack && key_inc;
  assign ack_dec = ack && !key_inc;
  assign ed_inc  = editing && !key_mode && !ring && key_inc;
  assign ed_dec  = editing && !key_mode && !ring && !key_inc && key_dec;

  always_comb begin
    sec_nx  = sec + 6'd1;
    min_nx  = min;
    hour_nx = hour;
    if (sec == 6'd59) begin
      sec_nx = 6'd0;
      min_nx = (min == 6'd59) ? 6'd0 : min + 6'd1;
      if (min == 6'd59) hour_nx = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
    end
  end

  always_comb begin
    state_nx = state;
    if (key_mode) begin
      case (state)
        RUN:     if (set_tgt <= TW'(N_ALARM)) state_nx = SET_H;
        SET_H:   state_nx = SET_M;
        SET_M:   state_nx = (edit_tgt == '0) ? SET_S : RUN;
        SET_S:   state_nx = RUN;
        default: state_nx = RUN;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= RUN;
      edit_tgt <= '0;
    end else begin
      state <= state_nx;
      if (state == RUN && key_mode && set_tgt <= TW'(N_ALARM)) edit_tgt <= set_tgt;
    end
  end

  assign edit_field = state;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hour <= 5'd0;
      min  <= 6'd0;
      sec  <= 6'd0;
    end else if (adv) begin
      hour <= hour_nx;
      min  <= min_nx;
      sec  <= sec_nx;
    end else if (time_edit && (ed_inc || ed_dec)) begin
      case (state)
        SET_H:   hour <= 5'(wrap_step({1'b0, hour}, 6'd23, ed_inc));
        SET_M:   min  <= wrap_step(min, 6'd59, ed_inc);
        SET_S:   sec  <= wrap_step(sec, 6'd59, ed_inc);
        default: ;
      endcase
    end
  end

`ifdef SNOOZE_EN
  logic [6:0] sn_msum;
  logic [5:0] sn_min;
  logic [4:0] sn_hour;

  always_comb begin
    sn_msum = {1'b0, min} + 7'(SNOOZE_MIN);
    sn_min  = sn_msum[5:0];
    sn_hour = hour;
    if (sn_msum >= 7'd60) begin
      sn_min  = 6'(sn_msum - 7'd60);
      sn_hour = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
    end
  end
`endif

  for (genvar i = 0; i < N_ALARM; i++) begin : g_ch
    logic sel;
    assign sel = editing && (edit_tgt == TW'(i + 1));

    rtc_alarm_chan u_chan (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .h_inc     (sel && state == SET_H && ed_inc),
      .h_dec     (sel && state == SET_H && ed_dec),
      .m_inc     (sel && state == SET_M && ed_inc),
      .m_dec     (sel && state == SET_M && ed_dec),
      .adv       (adv),
      .nx_hour   (hour_nx),
      .nx_min    (min_nx),
      .nx_top    (sec == 6'd59),
      .en        (alarm_en[i]),
      .excl      (sel),
`ifdef SNOOZE_EN
      .sn_load   (ack_dec && ring_ch[i]),
      .sn_cancel (ack_inc),
      .sn_hour   (sn_hour),
      .sn_min    (sn_min),
`endif
      .al_hour   (al_hour[i]),
      .al_min    (al_min[i]),
      .hit       (hit[i])
    );
  end

  always_comb begin
    rd_hour = 5'd0;
    rd_min  = 6'd0;
    for (int i = 0; i < N_ALARM; i++) begin
      if (rd_idx == TW'(i)) begin
        rd_hour = al_hour[i];
        rd_min  = al_min[i];
      end
    end
  end

  // A fresh match outranks a same-cycle acknowledge so a new alarm is never lost.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ring     <= 1'b0;
      ring_ch  <= '0;
      ring_cnt <= 8'd0;
    end else if (|hit) begin
      ring     <= 1'b1;
      ring_ch  <= (ack ? '0 : ring_ch) | hit;
      ring_cnt <= 8'(RING_SEC);
    end else if (ack) begin
      ring     <= 1'b0;
      ring_ch  <= '0;
      ring_cnt <= 8'd0;
    end else if (tick_1s && ring) begin
      if (ring_cnt <= 8'd1) begin
        ring     <= 1'b0;
        ring_ch  <= '0;
        ring_cnt <= 8'd0;
      end else begin
        ring_cnt <= ring_cnt - 8'd1;
      end
    end
  end

  wire unused_ack_dec = ack_dec ^ ack_inc;

endmodule

// File: tb/tb_rtc_alarm_core.sv
// Directed testbench for rtc_alarm_core (N_ALARM=2, RING_SEC=10, SNOOZE_MIN=5).

module tb_rtc_alarm_core;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       tick_1s = 1'b0, key_mode = 1'b0, key_inc = 1'b0, key_dec = 1'b0;
  logic [2:0] set_tgt = 3'd0, rd_idx = 3'd0, edit_tgt;
  logic [1:0] alarm_en = 2'd0, ring_ch, edit_field;
  logic [4:0] hour, rd_hour;
  logic [5:0] min, sec, rd_min;
  logic       ring;
  int         n_cmp = 0, n_err = 0;

  always #5 sys_clk = ~sys_clk;

  rtc_alarm_core #(.N_ALARM(2), .RING_SEC(10), .SNOOZE_MIN(5), .TW(3)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tick_1s(tick_1s),
    .key_mode(key_mode), .key_inc(key_inc), .key_dec(key_dec),
    .set_tgt(set_tgt), .alarm_en(alarm_en),
    .hour(hour), .min(min), .sec(sec),
    .edit_field(edit_field), .edit_tgt(edit_tgt),
    .rd_idx(rd_idx), .rd_hour(rd_hour), .rd_min(rd_min),
    .ring(ring), .ring_ch(ring_ch)
  );

  task automatic cyc(input logic t, input logic m, input logic i, input logic d);
    @(negedge sys_clk);
    tick_1s = t; key_mode = m; key_inc = i; key_dec = d;
    @(negedge sys_clk);
    tick_1s = 0; key_mode = 0; key_inc = 0; key_dec = 0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) cyc(1, 0, 0, 0);
  endtask

  task automatic step_field(input int from, input int to, input int modn);
    int diff;
    diff = (to - from + modn) % modn;
    if (diff <= modn / 2) for (int k = 0; k < diff; k++) cyc(0, 0, 1, 0);
    else for (int k = 0; k < modn - diff; k++) cyc(0, 0, 0, 1);
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst_n = 0; alarm_en = 0; set_tgt = 0; rd_idx = 0;
    @(negedge sys_clk);
    sys_rst_n = 1;
  endtask

  // Assumes time is 00:00:00.
  task automatic set_time(input int h, input int m, input int s);
    set_tgt = 0;
    cyc(0, 1, 0, 0); step_field(0, h, 24);
    cyc(0, 1, 0, 0); step_field(0, m, 60);
    cyc(0, 1, 0, 0); step_field(0, s, 60);
    cyc(0, 1, 0, 0);
  endtask

  // Assumes the channel still holds its reset value 00:05.
  task automatic set_alarm(input int ch, input int h, input int m);
    set_tgt = 3'(ch + 1);
    cyc(0, 1, 0, 0); step_field(0, h, 24);
    cyc(0, 1, 0, 0); step_field(5, m, 60);
    cyc(0, 1, 0, 0);
    set_tgt = 0;
  endtask

  task automatic test_reset();
    @(negedge sys_clk); @(negedge sys_clk);
    n_cmp++;
    if ({hour, min, sec} !== 17'd0) begin
      n_err++; $display("FAIL reset_time got %0d:%0d:%0d exp 0:0:0", hour, min, sec);
    end
    n_cmp++;
    if ({edit_field, edit_tgt, ring, ring_ch} !== 8'd0) begin
      n_err++; $display("FAIL reset_ctrl got f=%0d t=%0d r=%0d ch=%0d exp all 0",
                        edit_field, edit_tgt, ring, ring_ch);
    end
    sys_rst_n = 1;
    rd_idx = 1; #1;
    n_cmp++;
    if ({rd_hour, rd_min} !== {5'd0, 6'd5}) begin
      n_err++; $display("FAIL reset_alarm1 got %0d:%0d exp 0:5", rd_hour, rd_min);
    end
    rd_idx = 2; #1;
    n_cmp++;
    if ({rd_hour, rd_min} !== 11'd0) begin
      n_err++; $display("FAIL rd_out_of_range got %0d:%0d exp 0:0", rd_hour, rd_min);
    end
    rd_idx = 0;
  endtask

  task automatic test_count();
    do_reset();
    ticks(3661);
    n_cmp++;
    if ({hour, min, sec} !== {5'd1, 6'd1, 6'd1}) begin
      n_err++; $display("FAIL count_3661 got %0d:%0d:%0d exp 1:1:1", hour, min, sec);
    end
    do_reset();
    set_time(23, 59, 59);
    n_cmp++;
    if ({hour, min, sec} !== {5'd23, 6'd59, 6'd59}) begin
      n_err++; $display("FAIL preload got %0d:%0d:%0d exp 23:59:59", hour, min, sec);
    end
    ticks(1);
    n_cmp++;
    if ({hour, min, sec} !== 17'd0) begin
      n_err++; $display("FAIL midnight_wrap got %0d:%0d:%0d exp 0:0:0", hour, min, sec);
    end
  endtask

  task automatic test_edit_freeze();
    do_reset();
    set_time(10, 20, 30);
    cyc(0, 1, 0, 0);
    n_cmp++;
    if ({edit_field, edit_tgt} !== {2'd1, 3'd0}) begin
      n_err++; $display("FAIL edit_entry got f=%0d t=%0d exp f=1 t=0", edit_field, edit_tgt);
    end
    cyc(0, 1, 0, 0);
    for (int k = 0; k < 21; k++) cyc(0, 0, 0, 1);
    n_cmp++;
    if ({edit_field, hour, min, sec} !== {2'd2, 5'd10, 6'd59, 6'd30}) begin
      n_err++; $display("FAIL min_dec_wrap got f=%0d %0d:%0d:%0d exp f=2 10:59:30",
                        edit_field, hour, min, sec);
    end
    ticks(5);
    n_cmp++;
    if ({hour, min, sec} !== {5'd10, 6'd59, 6'd30}) begin
      n_err++; $display("FAIL frozen got %0d:%0d:%0d exp 10:59:30", hour, min, sec);
    end
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    ticks(1);
    n_cmp++;
    if ({edit_field, hour, min, sec} !== {2'd0, 5'd10, 6'd59, 6'd31}) begin
      n_err++; $display("FAIL resume got f=%0d %0d:%0d:%0d exp f=0 10:59:31",
                        edit_field, hour, min, sec);
    end
  endtask

  task automatic test_alarm_ring();
    do_reset();
    set_alarm(0, 7, 0);
    rd_idx = 0; #1;
    n_cmp++;
    if ({edit_field, rd_hour, rd_min} !== {2'd0, 5'd7, 6'd0}) begin
      n_err++; $display("FAIL alarm0_set got f=%0d %0d:%0d exp f=0 7:0", edit_field, rd_hour, rd_min);
    end
    set_time(6, 59, 59);
    alarm_en = 2'b01;
    ticks(1);
    n_cmp++;
    if ({ring, ring_ch, hour, min, sec} !== {1'b1, 2'b01, 5'd7, 6'd0, 6'd0}) begin
      n_err++; $display("FAIL ring_start got r=%0d ch=%0d %0d:%0d:%0d exp r=1 ch=1 7:0:0",
                        ring, ring_ch, hour, min, sec);
    end
    ticks(9);
    n_cmp++;
    if ({ring, ring_ch} !== 3'b101) begin
      n_err++; $display("FAIL ring_hold got r=%0d ch=%0d exp r=1 ch=1", ring, ring_ch);
    end
    ticks(1);
    n_cmp++;
    if ({ring, ring_ch} !== 3'b000) begin
      n_err++; $display("FAIL ring_expire got r=%0d ch=%0d exp r=0 ch=0", ring, ring_ch);
    end
  endtask

  task automatic test_two_ch_ack();
    do_reset();
    set_alarm(0, 7, 0);
    set_alarm(1, 7, 0);
    set_time(6, 59, 59);
    alarm_en = 2'b11;
    ticks(1);
    n_cmp++;
    if ({ring, ring_ch} !== 3'b111) begin
      n_err++; $display("FAIL two_ch got r=%0d ch=%0d exp r=1 ch=3", ring, ring_ch);
    end
    ticks(2);
    cyc(1, 0, 1, 0);
    n_cmp++;
    if ({ring, ring_ch, hour, min, sec} !== {1'b0, 2'b00, 5'd7, 6'd0, 6'd3}) begin
      n_err++; $display("FAIL inc_ack got r=%0d ch=%0d %0d:%0d:%0d exp r=0 ch=0 7:0:3",
                        ring, ring_ch, hour, min, sec);
    end
  endtask

  task automatic test_priority();
    do_reset();
    set_tgt = 0;
    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 0);
    n_cmp++;
    if ({edit_field, hour, min} !== {2'd2, 5'd0, 6'd0}) begin
      n_err++; $display("FAIL mode_over_inc got f=%0d %0d:%0d exp f=2 0:0", edit_field, hour, min);
    end
    cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 1);
    n_cmp++;
    if ({edit_field, hour} !== {2'd1, 5'd1}) begin
      n_err++; $display("FAIL inc_over_dec got f=%0d h=%0d exp f=1 h=1", edit_field, hour);
    end
    cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
    set_tgt = 5;
    cyc(0, 1, 0, 0);
    set_tgt = 3;
    cyc(0, 1, 0, 0);
    n_cmp++;
    if (edit_field !== 2'd0) begin
      n_err++; $display("FAIL tgt_out_of_range got f=%0d exp f=0", edit_field);
    end
    set_tgt = 2;
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0);
    rd_idx = 1; #1;
    n_cmp++;
    if ({edit_field, edit_tgt, rd_hour, rd_min, hour} !== {2'd1, 3'd2, 5'd1, 6'd5, 5'd1}) begin
      n_err++; $display("FAIL alarm1_edit got f=%0d t=%0d al=%0d:%0d h=%0d exp f=1 t=2 al=1:5 h=1",
                        edit_field, edit_tgt, rd_hour, rd_min, hour);
    end
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    n_cmp++;
    if (edit_field !== 2'd0) begin
      n_err++; $display("FAIL alarm_skip_sec got f=%0d exp f=0", edit_field);
    end
    rd_idx = 0;
  endtask

  task automatic test_dec_ack();
    logic exp_snz;
`ifdef SNOOZE_EN
    exp_snz = 1'b1;
`else
    exp_snz = 1'b0;
`endif
    do_reset();
    set_alarm(0, 7, 0);
    set_time(6, 59, 59);
    alarm_en = 2'b01;
    ticks(1);
    cyc(0, 0, 0, 1);
    n_cmp++;
    if ({ring, ring_ch, hour, min, sec} !== {1'b0, 2'b00, 5'd7, 6'd0, 6'd0}) begin
      n_err++; $display("FAIL dec_ack got r=%0d ch=%0d %0d:%0d:%0d exp r=0 ch=0 7:0:0",
                        ring, ring_ch, hour, min, sec);
    end
    alarm_en = 2'b00;
    ticks(300);
    rd_idx = 0; #1;
    n_cmp++;
    if ({ring, ring_ch, hour, min, sec} !== {exp_snz, 1'b0, exp_snz, 5'd7, 6'd5, 6'd0}) begin
      n_err++; $display("FAIL snooze_fire got r=%0d ch=%0d %0d:%0d:%0d exp r=%0d ch=%0d 7:5:0",
                        ring, ring_ch, hour, min, sec, exp_snz, exp_snz);
    end
    n_cmp++;
    if ({rd_hour, rd_min} !== {5'd7, 6'd0}) begin
      n_err++; $display("FAIL alarm_kept got %0d:%0d exp 7:0", rd_hour, rd_min);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_time(0, 4, 59);
    alarm_en = 2'b01;
    ticks(1);
    set_tgt = 1;
    cyc(0, 1, 0, 0);
    n_cmp++;
    if ({ring, edit_field} !== {1'b1, 2'd1}) begin
      n_err++; $display("FAIL mode_while_ring got r=%0d f=%0d exp r=1 f=1", ring, edit_field);
    end
    #2 sys_rst_n = 0;
    #1;
    n_cmp++;
    if ({ring, ring_ch, edit_field, edit_tgt, hour, min, sec} !== 25'd0) begin
      n_err++; $display("FAIL async_reset got r=%0d ch=%0d f=%0d t=%0d %0d:%0d:%0d exp all 0",
                        ring, ring_ch, edit_field, edit_tgt, hour, min, sec);
    end
    @(negedge sys_clk);
    sys_rst_n = 1; set_tgt = 0; alarm_en = 0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog expired after %0d compares", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_count();
    test_edit_freeze();
    test_alarm_ring();
    test_two_ch_ack();
    test_priority();
    test_dec_ack();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
